// File: rtl/dec5b4b_pkg.sv
// dec5b4b_pkg: shared definitions for the 5b return-path decoder.
//   - default bit periods for the 5b receive line and the 8N1 transmit line
//   - LED error codes shown in place of a byte
//   - receive / transmit FSM state encodings
//   - decode_sym(): 5-bit line symbol -> {valid, nibble}
package dec5b4b_pkg;

  localparam int RX_BIT_CLKS_DEF = 45;
  localparam int TX_BIT_CLKS_DEF = 54;

  localparam logic [7:0] LED_OVERRUN = 8'hAA;
  localparam logic [7:0] LED_FRAMING = 8'hBB;
  localparam logic [7:0] LED_SYMBOL  = 8'hCC;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  // Returns {valid, nibble}; any code outside the table decodes as invalid.
  function automatic logic [4:0] decode_sym(input logic [4:0] sym);
    case (sym)
      5'b11110: decode_sym = {1'b1, 4'h0};
      5'b01001: decode_sym = {1'b1, 4'h1};
      5'b10100: decode_sym = {1'b1, 4'h2};
      5'b10101: decode_sym = {1'b1, 4'h3};
      5'b01010: decode_sym = {1'b1, 4'h4};
      5'b01011: decode_sym = {1'b1, 4'h5};
      5'b01110: decode_sym = {1'b1, 4'h6};
      5'b01111: decode_sym = {1'b1, 4'h7};
      5'b10010: decode_sym = {1'b1, 4'h8};
      5'b10011: decode_sym = {1'b1, 4'h9};
      5'b10110: decode_sym = {1'b1, 4'hA};
      5'b10111: decode_sym = {1'b1, 4'hB};
      5'b11010: decode_sym = {1'b1, 4'hC};
      5'b11011: decode_sym = {1'b1, 4'hD};
      5'b11100: decode_sym = {1'b1, 4'hE};
      5'b11101: decode_sym = {1'b1, 4'hF};
      default:  decode_sym = 5'b0_0000;
    endcase
  endfunction

endpackage

// File: rtl/dec5b4b_921600_uart_tx.sv
// uart_tx_8n1: 8N1 serial transmitter, LSB first.
//   clk_i   system clock
//   rst_i   synchronous active-high reset (line returns high on the next edge)
//   data_i  byte to send, captured on an accepted load
//   load_i  load strobe
//   busy_o  high while a frame is in flight
//   txd_o   registered serial output, idles high
// Handshake: load_i is accepted only in a cycle where busy_o is low; a load
// offered while busy_o is high is ignored, so the caller must hold it.
module uart_tx_8n1
  import dec5b4b_pkg::*;
#(
  parameter int BIT_CLKS = TX_BIT_CLKS_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       load_i,
  output logic       busy_o,
  output logic       txd_o
);

  localparam logic [15:0] BIT_LAST = 16'(BIT_CLKS - 1);

  tx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shreg_q;
  logic        txd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= T_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        T_IDLE: begin
          if (load_i) begin
            shreg_q <= data_i;
            cnt_q   <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b0;
            state_q <= T_START;
          end
        end
        T_START: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            txd_q   <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[7:1]};
            state_q <= T_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        T_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= T_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              txd_q   <= shreg_q[0];
              shreg_q <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        T_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= T_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= T_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != T_IDLE);
  assign txd_o  = txd_q;

endmodule

// File: rtl/dec5b4b_921600.sv
// dec5b4b_921600: 5b return-path receiver -> byte -> 921600-baud 8N1 UART.
//   CLK_50M        50 MHz system clock
//   RST            synchronous active-high reset
//   RS232_DCE_RXD  asynchronous 12-bit 5b frames (start, lo sym, hi sym, stop)
//   RS232_DTE_TXD  decoded bytes as 8N1 UART, idles high
//   LED            last good byte, or AA/BB/CC error code
//   ERR            sticky flags: [0] framing, [1] invalid symbol, [2] overrun
module dec5b4b_921600
  import dec5b4b_pkg::*;
#(
  parameter int RX_BIT_CLKS = RX_BIT_CLKS_DEF,
  parameter int TX_BIT_CLKS = TX_BIT_CLKS_DEF
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       RS232_DCE_RXD,
  output logic       RS232_DTE_TXD,
  output logic [7:0] LED,
  output logic [2:0] ERR
);

  localparam logic [15:0] RX_HALF = 16'(RX_BIT_CLKS / 2 - 1);
  localparam logic [15:0] RX_LAST = 16'(RX_BIT_CLKS - 1);

  logic        rxd_s1_q, rxd_s2_q;
  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [3:0]  rx_bit_q;
  logic [9:0]  sym_q;
  logic        frame_done_q;
  logic        stop_bit_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic [7:0]  led_q;
  logic [2:0]  err_q;

  logic [4:0]  dec_lo, dec_hi;
  logic        sym_ok;
  logic [7:0]  rx_byte_d;
  logic        tx_busy, tx_load, tx_txd;

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= RS232_DCE_RXD;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // Receive FSM. The stop bit is sampled and the FSM drops straight back to
  // R_IDLE so a start edge arriving in the tail of the stop bit is caught.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      rx_state_q   <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      sym_q        <= '0;
      frame_done_q <= 1'b0;
      stop_bit_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (rx_state_q)
        R_IDLE: begin
          if (!rxd_s2_q) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt_q == RX_HALF) begin
            rx_cnt_q   <= '0;
            // A high start sample is a glitch, not a frame.
            rx_state_q <= rxd_s2_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        R_DATA: begin
          if (rx_cnt_q == RX_LAST) begin
            rx_cnt_q <= '0;
            sym_q    <= {rxd_s2_q, sym_q[9:1]};
            if (rx_bit_q == 4'd9) begin
              rx_state_q <= R_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 4'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        R_STOP: begin
          if (rx_cnt_q == RX_LAST) begin
            rx_cnt_q     <= '0;
            stop_bit_q   <= rxd_s2_q;
            frame_done_q <= 1'b1;
            rx_state_q   <= R_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  assign dec_lo    = decode_sym(sym_q[4:0]);
  assign dec_hi    = decode_sym(sym_q[9:5]);
  assign sym_ok    = dec_lo[4] & dec_hi[4];
  assign rx_byte_d = {dec_hi[3:0], dec_lo[3:0]};

  // The transmitter takes hold_q as it stands this cycle, so a write landing
  // in the same cycle as a load is not an overrun.
  assign tx_load = hold_full_q & ~tx_busy;

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      led_q       <= '0;
      err_q       <= '0;
    end else begin
      if (tx_load) begin
        hold_full_q <= 1'b0;
      end
      if (frame_done_q) begin
        if (!stop_bit_q) begin
          err_q[0] <= 1'b1;
          led_q    <= LED_FRAMING;
        end else if (!sym_ok) begin
          err_q[1] <= 1'b1;
          led_q    <= LED_SYMBOL;
        end else if (hold_full_q && !tx_load) begin
          err_q[2] <= 1'b1;
          led_q    <= LED_OVERRUN;
        end else begin
          hold_q      <= rx_byte_d;
          hold_full_q <= 1'b1;
          led_q       <= rx_byte_d;
        end
      end
    end
  end

  uart_tx_8n1 #(
    .BIT_CLKS (TX_BIT_CLKS)
  ) u_tx (
    .clk_i  (CLK_50M),
    .rst_i  (RST),
    .data_i (hold_q),
    .load_i (tx_load),
    .busy_o (tx_busy),
    .txd_o  (tx_txd)
  );

  assign RS232_DTE_TXD = tx_txd;
  assign LED           = led_q;
  assign ERR           = err_q;

endmodule
